led_step_sequencer: RTL and testbench
=====================================

LED_STEP_SEQUENCER -- requirements
Module: led_step_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000: clk cycles per step tick; legal values are 2 or more.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20: consecutive stable cycles needed to accept a button level; legal values are 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port btn_raw, input, 1 bit: asynchronous, bouncing flick button.
REQ-006 SHALL have port next_count, input, 5 bits: count from the next-state logic.
REQ-007 SHALL have port next_state, input, 3 bits: state from the next-state logic.
REQ-008 SHALL have port flick, output, 1 bit: registered, sticky flick request to the next-state logic.
REQ-009 SHALL have port current_count, output, 5 bits: registered count fed back to the next-state logic.
REQ-010 SHALL have port current_state, output, 3 bits: registered state fed back to the next-state logic.
REQ-011 SHALL have port step_tick, output, 1 bit: one-cycle pulse marking each step.
REQ-012 SHALL have port led, output, 16 bits: thermometer display of current_count.

Function
REQ-013 SHALL pass btn_raw through a 2-flop synchronizer before any other use.
REQ-014 SHALL change the debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle SHALL reset the debounce counter to 0.
REQ-015 SHALL set flick to 1 on the cycle after a 0->1 transition of the debounced level; a 1->0 transition SHALL have no effect.
REQ-016 SHALL run a prescaler 0..TICK_DIV-1 that wraps to 0; step_tick SHALL be 1 exactly in the cycles where the prescaler equals TICK_DIV-1.
REQ-017 On a step_tick cycle, SHALL load current_count<=next_count and current_state<=next_state at that clock edge, and SHALL clear flick.
REQ-018 SHALL hold current_count, current_state and flick unchanged between ticks.
REQ-019 SHALL treat the next-state logic's state values 0..6 (INIT, TURN_ON_TO_15, TURN_OFF_TO_5, TURN_ON_TO_10, TURN_OFF_TO_0, TURN_ON_TO_5, TURN_OFF_TO_0_END) as legal.
REQ-020 SHALL treat next_state=7 as illegal; on such a tick it SHALL load current_state=INIT (0) and current_count=0.
REQ-021 SHALL give precedence to the set when a debounced rising edge and step_tick occur in the same cycle: flick is 1 after the edge, and that request is carried to the following tick.
REQ-022 SHALL let multiple rising edges between two ticks collapse into a single request.
REQ-023 SHALL drive led[i] = 1 iff i < current_count, for i = 0..15, combinational from the register outputs.
REQ-024 SHALL drive led = 16'hFFFF for current_count values 16..31, with no wrap.
REQ-025 Latency: a button press SHALL be visible on flick 2 + DEBOUNCE_CYCLES + 1 cycles after btn_raw settles high.
REQ-025a The press SHALL be consumed at the first step_tick at or after it becomes visible on flick.

Reset
REQ-026 While rst is 1 at a clock edge, SHALL force current_count=0, current_state=INIT, flick=0, step_tick=0, prescaler=0, debounce counter=0, debounced level=0 and synchronizer flops=0, so led=0.
REQ-027 Reset mid-operation SHALL discard any pending flick.
REQ-027a After reset is released, the first step_tick SHALL occur TICK_DIV cycles later.

Structure
REQ-028 SHALL take the state encodings INIT..TURN_OFF_TO_0_END and widths COUNT_W=5, STATE_W=3 from the shared package, which the next-state logic also uses.
REQ-029 SHALL implement synchronizer, debounce and rising-edge detect in one sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, rise_pulse).
REQ-030 SHALL size the prescaler at $clog2(TICK_DIV) bits.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-031 Reset check: hold rst for 2 cycles then release -> all outputs 0, current_state=INIT; step_tick 1 in cycles 4, 8, 12 after release.
REQ-032 Bounce rejection: toggle btn_raw 1,0,1,0 one cycle each -> flick stays 0. Clean press held for 6 cycles -> flick=1 at cycle 6 after the press, and flick=0 after the next step_tick.
REQ-033 Step load: next_count=15 and next_state=1 held -> after the tick, current_count=15, current_state=1, led=16'h7FFF. With next_count=16 -> led=16'hFFFF.
REQ-034 Illegal state: next_state=7 and next_count=9 at a tick -> current_state=0 and current_count=0.
REQ-035 Collision: debounced edge lands in a step_tick cycle -> flick=1 afterward and is cleared only at the next tick. Two presses between ticks -> a single flick.
REQ-036 Mid-reset: flick pending and current_count=10, then assert rst for 1 cycle -> flick=0, current_count=0, led=0, and the prescaler restarts.

Source files
------------

// File: rtl/led_step_sequencer_pkg.sv
// Shared widths and state encodings for the LED step sequencer
// and the next-state logic that drives it.
package led_step_sequencer_pkg;

    localparam int COUNT_W = 5;
    localparam int STATE_W = 3;
    localparam int LED_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        INIT              = 3'd0,
        TURN_ON_TO_15     = 3'd1,
        TURN_OFF_TO_5     = 3'd2,
        TURN_ON_TO_10     = 3'd3,
        TURN_OFF_TO_0     = 3'd4,
        TURN_ON_TO_5      = 3'd5,
        TURN_OFF_TO_0_END = 3'd6
    } state_t;

    localparam logic [STATE_W-1:0] STATE_ILLEGAL = 3'd7;

    function automatic logic state_legal(input logic [STATE_W-1:0] s);
        return s != STATE_ILLEGAL;
    endfunction

    // Counts above LED_W saturate to all-on rather than wrapping.
    function automatic logic [LED_W-1:0] therm(
        input logic [COUNT_W-1:0] c
    );
        logic [LED_W-1:0] v;
        v = '0;
        for (int i = 0; i < LED_W; i++) begin
            v[i] = (i < int'(c));
        end
        return v;
    endfunction

endpackage

// File: rtl/led_step_sequencer_btn_debounce.sv
// Button synchronizer, level debouncer and rising-edge detector.
// rise_pulse is registered and lasts one cycle per accepted press.
module btn_debounce
    import led_step_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic rise_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            level      <= 1'b0;
            cnt        <= '0;
            rise_pulse <= 1'b0;
        end else begin
            sync_a     <= btn_raw;
            sync_b     <= sync_a;
            rise_pulse <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Disagreement has lasted long enough: accept the new level.
                cnt        <= '0;
                level      <= sync_b;
                rise_pulse <= sync_b;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_step_sequencer.sv
// Step-timed register bank for an external next-state block, with a
// debounced sticky flick request and a thermometer LED display.
module led_step_sequencer
    import led_step_sequencer_pkg::*;
#(
    parameter int TICK_DIV        = 25000000,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_raw,
    input  logic [COUNT_W-1:0] next_count,
    input  logic [STATE_W-1:0] next_state,
    output logic               flick,
    output logic [COUNT_W-1:0] current_count,
    output logic [STATE_W-1:0] current_state,
    output logic               step_tick,
    output logic [LED_W-1:0]   led
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic          rise_pulse;
    logic [PW-1:0] presc;
    state_t        state_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .rise_pulse (rise_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign step_tick = (presc == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            current_count <= '0;
            state_q       <= INIT;
        end else if (step_tick) begin
            if (state_legal(next_state)) begin
                current_count <= next_count;
                state_q       <= state_t'(next_state);
            end else begin
                current_count <= '0;
                state_q       <= INIT;
            end
        end
    end

    // A fresh press wins over a consuming tick so it is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            flick <= 1'b0;
        end else if (rise_pulse) begin
            flick <= 1'b1;
        end else if (step_tick) begin
            flick <= 1'b0;
        end
    end

    assign current_state = state_q;
    assign led           = therm(current_count);

endmodule

// File: tb/tb_led_step_sequencer.sv
// Directed self-checking bench for led_step_sequencer.
// Cycle n = the n-th clock period after the last reset edge.
module tb_led_step_sequencer;
    import led_step_sequencer_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               btn_raw = 1'b0;
    logic [COUNT_W-1:0] next_count = '0;
    logic [STATE_W-1:0] next_state = '0;
    logic               flick;
    logic [COUNT_W-1:0] current_count;
    logic [STATE_W-1:0] current_state;
    logic               step_tick;
    logic [LED_W-1:0]   led;

    logic               rst2 = 1'b1;
    logic               btn2 = 1'b0;
    logic [COUNT_W-1:0] next_count2 = '0;
    logic [STATE_W-1:0] next_state2 = '0;
    logic               flick2;
    logic [COUNT_W-1:0] count2;
    logic [STATE_W-1:0] state2;
    logic               tick2;
    logic [LED_W-1:0]   led2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    led_step_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .next_count    (next_count),
        .next_state    (next_state),
        .flick         (flick),
        .current_count (current_count),
        .current_state (current_state),
        .step_tick     (step_tick),
        .led           (led)
    );

    // Slow-tick instance so two full presses fit between ticks.
    led_step_sequencer #(.TICK_DIV(32), .DEBOUNCE_CYCLES(3)) u_dut2 (
        .clk           (clk),
        .rst           (rst2),
        .btn_raw       (btn2),
        .next_count    (next_count2),
        .next_state    (next_state2),
        .flick         (flick2),
        .current_count (count2),
        .current_state (state2),
        .step_tick     (tick2),
        .led           (led2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc%0d: got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        cyc = 1;
        check("rst_flick", 32'(flick), 0);
        check("rst_count", 32'(current_count), 0);
        check("rst_state", 32'(current_state), 32'(INIT));
        check("rst_led", 32'(led), 0);
        for (int i = 1; i <= 12; i++) begin
            go_to(i);
            check("tick_phase", 32'(step_tick), 32'((i % 4) == 0));
        end

        next_count = 5'd15;
        next_state = 3'd1;
        go_to(13);
        check("load_count", 32'(current_count), 15);
        check("load_state", 32'(current_state), 1);
        check("load_led", 32'(led), 32'h7FFF);
        next_count = 5'd16;
        go_to(15);
        check("hold_count", 32'(current_count), 15);
        go_to(17);
        check("sat_count", 32'(current_count), 16);
        check("sat_led", 32'(led), 32'hFFFF);

        next_count = 5'd9;
        next_state = 3'd7;
        go_to(21);
        check("illegal_state", 32'(current_state), 0);
        check("illegal_count", 32'(current_count), 0);
        next_count = 5'd5;
        next_state = 3'd2;

        btn_raw = 1'b1;
        step();
        btn_raw = 1'b0;
        step();
        btn_raw = 1'b1;
        step();
        btn_raw = 1'b0;
        for (int i = 25; i <= 32; i++) begin
            go_to(i);
            check("bounce_flick", 32'(flick), 0);
        end

        btn_raw = 1'b1;
        go_to(37);
        check("press_early", 32'(flick), 0);
        go_to(38);
        check("press_flick", 32'(flick), 1);
        go_to(40);
        check("press_held", 32'(flick), 1);
        go_to(41);
        check("press_consumed", 32'(flick), 0);
        btn_raw = 1'b0;
        go_to(48);
        check("release_noeff", 32'(flick), 0);

        go_to(51);
        btn_raw = 1'b1;
        go_to(56);
        check("coll_tick", 32'(step_tick), 1);
        check("coll_before", 32'(flick), 0);
        go_to(57);
        check("coll_set", 32'(flick), 1);
        next_count = 5'd10;
        next_state = 3'd3;
        go_to(60);
        check("coll_carried", 32'(flick), 1);
        go_to(61);
        check("coll_cleared", 32'(flick), 0);
        btn_raw = 1'b0;

        go_to(67);
        btn_raw = 1'b1;
        go_to(73);
        check("mid_pending", 32'(flick), 1);
        check("mid_count", 32'(current_count), 10);
        rst = 1'b1;
        btn_raw = 1'b0;
        go_to(74);
        check("mid_flick", 32'(flick), 0);
        check("mid_cnt0", 32'(current_count), 0);
        check("mid_led", 32'(led), 0);
        check("mid_state", 32'(current_state), 0);
        check("mid_tick", 32'(step_tick), 0);
        rst = 1'b0;
        cyc = 1;
        go_to(3);
        check("restart_t3", 32'(step_tick), 0);
        go_to(4);
        check("restart_t4", 32'(step_tick), 1);

        step();
        rst2 = 1'b0;
        cyc = 1;
        next_count2 = 5'd7;
        next_state2 = 3'd4;
        go_to(2);
        btn2 = 1'b1;
        go_to(8);
        check("dup_first", 32'(flick2), 1);
        btn2 = 1'b0;
        go_to(13);
        btn2 = 1'b1;
        go_to(19);
        check("dup_second", 32'(flick2), 1);
        btn2 = 1'b0;
        go_to(31);
        check("dup_pretick", 32'(tick2), 0);
        check("dup_preload", 32'(count2), 0);
        go_to(32);
        check("dup_tick", 32'(tick2), 1);
        go_to(33);
        check("dup_single", 32'(flick2), 0);
        check("dup_load", 32'(count2), 7);
        check("dup_led", 32'(led2), 32'h007F);
        go_to(40);
        check("dup_stays", 32'(flick2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
